alu_stage: RTL and testbench
============================

Name: alu_stage

Overview:
- Registered 8-bit ALU stage directly downstream of the A and B registers; consumes their outputs and produces a result byte for the shared bus.
- Start/busy/done handshake.
- Single-cycle ops complete in one EXEC cycle; MUL runs an 8-iteration shift-add sequence.
- Result and flags are held until the next operation completes; the bus-facing output updates only on OE, matching the register-stage bus discipline.

Parameters:
- WIDTH, 8, operand/result width; the design is verified only at 8.
- MUL_EN, 1, enables the MUL opcode; when 0, opcode 101 behaves as ADD.

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- A_in  input  WIDTH  operand A, from the A register output.
- B_in  input  WIDTH  operand B, from the B register output.
- op  input  3  opcode, sampled together with start.
- start  input  1  request; accepted only in IDLE.
- OE  input  1  copy the held result to ALU_out.
- busy  output  1  high while state != IDLE.
- done  output  1  one-cycle pulse when the result and flags are updated.
- ALU_out  output  WIDTH  registered bus-facing result.
- flags  output  4  {C,Z,N,V}, registered.

Behaviour:
- Clock and reset: one clock (CLK). RESET is asynchronous, active-high; it forces state=IDLE and clears busy, done, ALU_out, flags, the internal result, operand latches and iteration count. Reset mid-operation aborts with no done pulse.
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A-B.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 MUL: low byte of A*B.
  - 110 INC: A+1.
  - 111 PASSB: B.
- States:
  - IDLE: at an edge with start=1, latch A_in, B_in and op, then go to EXEC, or to MUL if op=101 and MUL_EN=1. start=0 stays in IDLE.
  - EXEC: at the next edge, write result and flags, pulse done, return to IDLE. Start-to-done latency is 2 edges.
  - MUL: acc cleared at entry. On each edge, if multiplier bit0=1 then acc+=multiplicand (16-bit); multiplicand<<=1; multiplier>>=1; count++. At the 8th MUL edge (count 7->8), write result=acc[7:0] and flags, pulse done, return to IDLE. Start-to-done latency is 9 edges.
- busy is high in EXEC and MUL. start while busy is ignored (not queued). A_in, B_in and op changes while busy have no effect.
- done is high for exactly one cycle following the completing edge. A new start is accepted at the edge after done is seen, with no bubble required beyond IDLE.
- Flags:
  - Z = (result==0); N = result[7] (all ops).
  - ADD/INC: C = carry out of bit 7; V = signed overflow.
  - SUB: C = 1 when A>=B unsigned (no borrow); V = signed overflow of A-B.
  - AND/OR/XOR/PASSB: C=0, V=0.
  - MUL: C = (acc[15:8]!=0); V=0.
- OE: at an edge with OE=1 and state=IDLE, ALU_out <= held result. OE while busy is ignored and ALU_out holds. With OE=0, ALU_out holds its last value.
- Simultaneous events:
  - start and OE in the same IDLE edge: both act. ALU_out takes the previous result; the new op begins.
  - OE in the cycle done is high: state is IDLE, so ALU_out takes the new result.
- Arithmetic wraps modulo 2^WIDTH: 0xFF+1 = 0x00 with C=1, Z=1.

Test Plan:
- ADD wrap: RESET, then start op=000 with A=0xFF, B=0x01 -> done 2 edges later; flags C=1,Z=1,N=0,V=0; OE pulse -> ALU_out=0x00.
- SUB signed overflow: A=0x80, B=0x01 -> result 0x7F; C=1,Z=0,N=0,V=1. Then A=0x03, B=0x05 -> result 0xFE; C=0,N=1.
- MUL timing: A=0x0C, B=0x0B -> busy for 9 edges, single done pulse, result 0x84, C=0. Then A=0x10, B=0x10 -> result 0x00, Z=1, C=1.
- Ignored inputs while busy: during MUL, assert start with op=010 and OE, and change A_in/B_in -> MUL result is unchanged, no extra op runs, and ALU_out holds its old value until OE after done.
- Reset mid-MUL: assert RESET at the 4th MUL edge -> busy=0, done never pulses, ALU_out=0x00, flags=0. Next start op=111 with B=0x5A -> result 0x5A, Z=0, N=0.
- Back-to-back: start at the edge after done, with OE asserted on that same edge -> ALU_out holds the previous result and the new op completes 2 edges later.

Source files
------------

// File: rtl/alu_stage.sv
// rtl/alu_stage.sv - registered 8-bit ALU stage with start/busy/done handshake and shift-add multiply
module alu_stage #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic             OE,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALU_out,
  output logic [3:0]       flags
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_OR    = 3'b011;
  localparam logic [2:0] OP_XOR   = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_INC   = 3'b110;
  localparam logic [2:0] OP_PASSB = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MUL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2:0]         r_op;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_result;
  logic [3:0]         r_flags;
  logic               r_done;
  logic [WIDTH-1:0]   r_alu_out;

  logic               w_load;
  logic               w_exec_wr;
  logic               w_mul_last;
  logic               w_mul_wr;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_exec_res;
  logic               w_exec_c;
  logic               w_exec_v;
  logic [3:0]         w_exec_flags;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   w_mul_res;
  logic [3:0]         w_mul_flags;

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = ((op == OP_MUL) && MUL_EN) ? S_MUL : S_EXEC;
        end
      end
      S_EXEC:  w_next = S_IDLE;
      S_MUL:   w_next = w_mul_last ? S_IDLE : S_MUL;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs and control strobes
  always_comb begin
    busy       = (r_state != S_IDLE);
    w_load     = (r_state == S_IDLE) && start;
    w_exec_wr  = (r_state == S_EXEC);
    w_mul_last = (r_state == S_MUL) && (r_count == CW'(WIDTH - 1));
    w_mul_wr   = w_mul_last;
  end

  // Single-cycle datapath; MUL only reaches EXEC when MUL_EN=0 and then acts as ADD
  always_comb begin
    w_addend   = (r_op == OP_INC) ? WIDTH'(1) : r_b;
    w_sum      = {1'b0, r_a} + {1'b0, w_addend};
    w_diff     = {1'b0, r_a} - {1'b0, r_b};
    w_exec_res = w_sum[WIDTH-1:0];
    w_exec_c   = 1'b0;
    w_exec_v   = 1'b0;
    case (r_op)
      OP_SUB: begin
        w_exec_res = w_diff[WIDTH-1:0];
        w_exec_c   = ~w_diff[WIDTH];
        w_exec_v   = (r_a[MSB] != r_b[MSB]) && (w_diff[MSB] != r_a[MSB]);
      end
      OP_AND:   w_exec_res = r_a & r_b;
      OP_OR:    w_exec_res = r_a | r_b;
      OP_XOR:   w_exec_res = r_a ^ r_b;
      OP_PASSB: w_exec_res = r_b;
      default: begin
        w_exec_res = w_sum[WIDTH-1:0];
        w_exec_c   = w_sum[WIDTH];
        w_exec_v   = (r_a[MSB] == w_addend[MSB]) && (w_sum[MSB] != r_a[MSB]);
      end
    endcase
    w_exec_flags = {w_exec_c, (w_exec_res == '0), w_exec_res[MSB], w_exec_v};
  end

  // Shift-add step; the completing edge stores the accumulator value it produces
  always_comb begin
    w_acc_next  = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_mul_res   = w_acc_next[WIDTH-1:0];
    w_mul_flags = {(w_acc_next[2*WIDTH-1:WIDTH] != '0), (w_mul_res == '0), w_mul_res[MSB], 1'b0};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_count   <= '0;
      r_result  <= '0;
      r_flags   <= '0;
      r_done    <= 1'b0;
      r_alu_out <= '0;
    end else begin
      r_done <= w_exec_wr | w_mul_wr;

      if (w_load) begin
        r_a      <= A_in;
        r_b      <= B_in;
        r_op     <= op;
        r_acc    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, A_in};
        r_mplier <= B_in;
        r_count  <= '0;
      end else if (r_state == S_MUL) begin
        r_acc    <= w_acc_next;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_count  <= r_count + CW'(1);
      end

      if (w_exec_wr) begin
        r_result <= w_exec_res;
        r_flags  <= w_exec_flags;
      end else if (w_mul_wr) begin
        r_result <= w_mul_res;
        r_flags  <= w_mul_flags;
      end

      // Bus copy sees the held result as of this edge, before any same-edge update
      if (OE && (r_state == S_IDLE)) begin
        r_alu_out <= r_result;
      end
    end
  end

  assign done    = r_done;
  assign ALU_out = r_alu_out;
  assign flags   = r_flags;

endmodule

// File: tb/tb_alu_stage.sv
// tb/tb_alu_stage.sv - table-driven scoreboard bench for alu_stage
module tb_alu_stage;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] A_in;
  logic [7:0] B_in;
  logic [2:0] op;
  logic       start;
  logic       OE;
  logic       busy;
  logic       done;
  logic [7:0] ALU_out;
  logic [3:0] flags;

  alu_stage #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .A_in(A_in), .B_in(B_in), .op(op),
    .start(start), .OE(OE), .busy(busy), .done(done),
    .ALU_out(ALU_out), .flags(flags)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] res;
    logic [3:0] flg;
    int         due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic [3:0] flg;
    int         lat;
  } vec_t;
  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called just after a falling edge; leaves start released one cycle later
  task automatic start_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] res, input logic [3:0] flg, input int lat,
                          input logic oe);
    exp_t e;
    A_in  = a;
    B_in  = b;
    op    = o;
    start = 1'b1;
    OE    = oe;
    e.res = res;
    e.flg = flg;
    e.due = cyc + lat;
    sb.push_back(e);
    @(negedge CLK);
    start = 1'b0;
    OE    = 1'b0;
  endtask

  task automatic wait_done(output logic [7:0] res);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    res  = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", {31'b0, seen}, 32'd1);
    if (seen) begin
      check("sb_has_entry", {31'b0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("flags", {28'b0, flags}, {28'b0, e.flg});
        check("latency", cyc, e.due);
        res = e.res;
      end
    end
  endtask

  task automatic oe_check(input logic [7:0] exp);
    OE = 1'b1;
    @(negedge CLK);
    OE = 1'b0;
    check("alu_out", {24'b0, ALU_out}, {24'b0, exp});
    check("done_single", {31'b0, done}, 32'd0);
  endtask

  task automatic do_vec(input vec_t v);
    logic [7:0] r;
    start_op(v.op, v.a, v.b, v.res, v.flg, v.lat, 1'b0);
    wait_done(r);
    oe_check(r);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    bit         saw_done;

    // op, a, b, result, {C,Z,N,V}, latency
    vecs[0]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 4'b1100, 2};
    vecs[1]  = '{3'b001, 8'h80, 8'h01, 8'h7F, 4'b1001, 2};
    vecs[2]  = '{3'b001, 8'h03, 8'h05, 8'hFE, 4'b0010, 2};
    vecs[3]  = '{3'b101, 8'h0C, 8'h0B, 8'h84, 4'b0010, 9};
    vecs[4]  = '{3'b101, 8'h10, 8'h10, 8'h00, 4'b1100, 9};
    vecs[5]  = '{3'b010, 8'hF0, 8'h3C, 8'h30, 4'b0000, 2};
    vecs[6]  = '{3'b011, 8'h0F, 8'hF0, 8'hFF, 4'b0010, 2};
    vecs[7]  = '{3'b100, 8'hAA, 8'hAA, 8'h00, 4'b0100, 2};
    vecs[8]  = '{3'b110, 8'h7F, 8'h33, 8'h80, 4'b0011, 2};
    vecs[9]  = '{3'b111, 8'h11, 8'h5A, 8'h5A, 4'b0000, 2};
    vecs[10] = '{3'b000, 8'h7F, 8'h01, 8'h80, 4'b0011, 2};
    vecs[11] = '{3'b001, 8'h05, 8'h05, 8'h00, 4'b1100, 2};
    vecs[12] = '{3'b110, 8'hFF, 8'h00, 8'h00, 4'b1100, 2};
    vecs[13] = '{3'b000, 8'h80, 8'h80, 8'h00, 4'b1101, 2};
    vecs[14] = '{3'b101, 8'hFF, 8'hFF, 8'h01, 4'b1000, 9};

    RESET = 1'b1;
    start = 1'b0;
    OE    = 1'b0;
    A_in  = 8'h00;
    B_in  = 8'h00;
    op    = 3'b000;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_busy",    {31'b0, busy},    32'd0);
    check("rst_done",    {31'b0, done},    32'd0);
    check("rst_alu_out", {24'b0, ALU_out}, 32'd0);
    check("rst_flags",   {28'b0, flags},   32'd0);

    for (int i = 0; i < 15; i++) begin
      do_vec(vecs[i]);
    end

    // MUL with start/OE/operand noise while busy; ALU_out still holds 0x01
    start_op(3'b101, 8'h0C, 8'h0B, 8'h84, 4'b0010, 9, 1'b0);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1;
      op    = 3'b010;
      A_in  = 8'hFF;
      B_in  = 8'hFF;
      OE    = 1'b1;
      @(negedge CLK);
      check("busy_during_mul", {31'b0, busy}, 32'd1);
      check("alu_out_hold_busy", {24'b0, ALU_out}, 32'h01);
    end
    start = 1'b0;
    OE    = 1'b0;
    wait_done(r);
    check("alu_out_hold_done", {24'b0, ALU_out}, 32'h01);
    oe_check(r);
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (done || busy) saw_done = 1'b1;
    end
    check("no_extra_op", {31'b0, saw_done}, 32'd0);
    check("sb_drained", sb.size(), 32'd0);

    // Reset at the 4th MUL edge aborts with no done
    A_in  = 8'h0C;
    B_in  = 8'h0B;
    op    = 3'b101;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("rstmid_busy_async", {31'b0, busy}, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    check("rstmid_busy",    {31'b0, busy},    32'd0);
    check("rstmid_done",    {31'b0, done},    32'd0);
    check("rstmid_alu_out", {24'b0, ALU_out}, 32'd0);
    check("rstmid_flags",   {28'b0, flags},   32'd0);
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge CLK);
      if (done) saw_done = 1'b1;
    end
    check("rstmid_no_done", {31'b0, saw_done}, 32'd0);
    do_vec('{3'b111, 8'h33, 8'h5A, 8'h5A, 4'b0000, 2});

    // Back-to-back: new start with OE on the done cycle
    start_op(3'b000, 8'h01, 8'h02, 8'h03, 4'b0000, 2, 1'b0);
    wait_done(r);
    start_op(3'b100, 8'h0F, 8'hF0, 8'hFF, 4'b0010, 2, 1'b1);
    check("b2b_alu_out_prev", {24'b0, ALU_out}, 32'h03);
    check("b2b_busy",         {31'b0, busy},    32'd1);
    wait_done(r);
    oe_check(r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
